mult_div_unit: RTL and testbench

Multicycle MULT/MULTU/DIV/DIVU engine for the MIPS datapath, fed directly by the A and B operand registers.
Started by the control unit from its execute state. It owns the HI and LO architectural registers.
HI/LO feed the register-bank write-data mux for MFHI/MFLO.
Iterative radix-2 algorithm: one partial-product or quotient bit per cycle.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 21 ++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multiply/divide engine
package mips_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'b00,
    MD_S_MUL  = 2'b01,
    MD_S_DIV  = 2'b10,
    MD_S_FIX  = 2'b11
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between control unit and mult_div_unit
interface mult_div_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) ();

  logic             Start;
  md_op_t           Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, Op, A, B, input Busy, Done, DivZero, Hi, Lo);
  modport slave  (input Start, Op, A, B, output Busy, Done, DivZero, Hi, Lo);

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO
// Operands are reduced to magnitudes at start; signs are reapplied in the FIX state.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic           Clk,
  input  logic           Reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic               div_op;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  assign signed_op = (bus.Op == MD_MULT) || (bus.Op == MD_DIV);
  assign div_op    = (bus.Op == MD_DIV) || (bus.Op == MD_DIVU);

  // acc low half holds the multiplier (MUL) or the dividend shifting into the quotient (DIV)
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign product   = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      MD_S_IDLE: begin
        if (bus.Start) begin
          cnt_d    = '0;
          dz_d     = 1'b0;
          is_div_d = div_op;
          neg_d    = signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          rneg_d   = signed_op && bus.A[WIDTH-1];
          opnd_d   = neg_if(bus.B, signed_op && bus.B[WIDTH-1]);
          acc_d    = {{WIDTH{1'b0}}, neg_if(bus.A, signed_op && bus.A[WIDTH-1])};
          rem_d    = '0;
          if (!div_op) begin
            state_d = MD_S_MUL;
            busy_d  = 1'b1;
          end else if (bus.B == '0) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = MD_S_DIV;
            busy_d  = 1'b1;
          end
        end
      end
      MD_S_MUL: begin
        acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = MD_S_FIX;
      end
      MD_S_DIV: begin
        // restoring step: keep the trial difference only when it did not borrow
        if (div_trial[WIDTH]) begin
          rem_d = div_shift;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = div_trial;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = MD_S_FIX;
      end
      MD_S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_if(acc_q[WIDTH-1:0], neg_q);
          hi_d = neg_if(rem_q[WIDTH-1:0], rneg_q);
        end else begin
          {hi_d, lo_d} = product;
        end
        done_d  = 1'b1;
        state_d = MD_S_IDLE;
      end
      default: state_d = MD_S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= MD_S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected HI/LO/DivZero and Done latency from the instruction semantics
  task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    exp_dz = 1'b0;
    lat    = 34;
    case (op)
      MD_MULT: begin
        p = sa * sb;
        {exp_hi, exp_lo} = p;
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {exp_hi, exp_lo} = p;
      end
      default: begin
        if (b == 32'd0) begin
          exp_dz = 1'b1;
          lat    = 1;
        end else if (op == MD_DIV) begin
          q = sa / sb;
          r = sa % sb;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic start_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (bus.Done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = MD_MULT;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.Busy, bus.Done, bus.DivZero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags act=%b exp=000", {bus.Busy, bus.Done, bus.DivZero});
    end
    checks++;
    if ({bus.Hi, bus.Lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo act=%h exp=0", {bus.Hi, bus.Lo});
    end
  endtask

  task automatic test_directed;
    md_op_t      d_op[6] = '{MD_MULT, MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] d_a[6]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] d_b[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] d_hi[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0};
    logic [31:0] d_lo[6] = '{32'hFFFFFFEB, 32'h1, 32'h1, 32'hFFFFFFFD, 32'd14, 32'h80000000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(d_op[i], d_a[i], d_b[i]);
      checks++;
      if (bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_busy act=%b exp=1", i, bus.Busy);
      end
      lat = 1;
      wait_done(lat);
      checks++;
      if (lat !== 34) begin
        failures++;
        $display("FAIL dir%0d_latency act=%0d exp=34", i, lat);
      end
      checks++;
      if ({bus.Hi, bus.Lo, bus.Busy, bus.DivZero} !== {d_hi[i], d_lo[i], 2'b00}) begin
        failures++;
        $display("FAIL dir%0d_result act=%h_%h busy=%b dz=%b exp=%h_%h busy=0 dz=0",
                 i, bus.Hi, bus.Lo, bus.Busy, bus.DivZero, d_hi[i], d_lo[i]);
      end
      tick();
      checks++;
      if (bus.Done !== 1'b0 || {bus.Hi, bus.Lo} !== {d_hi[i], d_lo[i]}) begin
        failures++;
        $display("FAIL dir%0d_after act=done%b %h_%h exp=done0 %h_%h",
                 i, bus.Done, bus.Hi, bus.Lo, d_hi[i], d_lo[i]);
      end
      exp_hi = d_hi[i];
      exp_lo = d_lo[i];
    end
  endtask

  task automatic test_divzero;
    int lat;
    start_op(MD_DIVU, 32'd1207, 32'd35);
    lat = 1;
    wait_done(lat);
    checks++;
    if ({bus.Hi, bus.Lo} !== {32'h11, 32'h22}) begin
      failures++;
      $display("FAIL dz_setup act=%h_%h exp=00000011_00000022", bus.Hi, bus.Lo);
    end
    tick();
    start_op(MD_DIV, 32'd5, 32'd0);
    checks++;
    if ({bus.Done, bus.DivZero, bus.Busy} !== 3'b110 || {bus.Hi, bus.Lo} !== {32'h11, 32'h22}) begin
      failures++;
      $display("FAIL dz_pulse act=done%b dz%b busy%b %h_%h exp=done1 dz1 busy0 00000011_00000022",
               bus.Done, bus.DivZero, bus.Busy, bus.Hi, bus.Lo);
    end
    repeat (3) tick();
    checks++;
    if ({bus.Done, bus.DivZero} !== 2'b01) begin
      failures++;
      $display("FAIL dz_sticky act=done%b dz%b exp=done0 dz1", bus.Done, bus.DivZero);
    end
    start_op(MD_MULTU, 32'd3, 32'd4);
    checks++;
    if (bus.DivZero !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear act=%b exp=0", bus.DivZero);
    end
    lat = 1;
    wait_done(lat);
    checks++;
    if (lat !== 34 || {bus.Hi, bus.Lo, bus.DivZero} !== {32'd0, 32'd12, 1'b0}) begin
      failures++;
      $display("FAIL dz_followup act=lat%0d %h_%h dz%b exp=lat34 00000000_0000000c dz0",
               lat, bus.Hi, bus.Lo, bus.DivZero);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd12;
  endtask

  task automatic test_random;
    md_op_t      op;
    logic [31:0] a, b;
    int          elat, lat;
    for (int i = 0; i < 30; i++) begin
      op = md_op_t'($urandom_range(0, 3));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom() : $urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      model(op, a, b, elat);
      start_op(op, a, b);
      lat = 1;
      wait_done(lat);
      checks++;
      if (lat !== elat || {bus.Hi, bus.Lo, bus.DivZero} !== {exp_hi, exp_lo, exp_dz}) begin
        failures++;
        $display("FAIL rnd%0d op%0d a=%h b=%h act=lat%0d %h_%h dz%b exp=lat%0d %h_%h dz%b",
                 i, op, a, b, lat, bus.Hi, bus.Lo, bus.DivZero, elat, exp_hi, exp_lo, exp_dz);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_ignored_start;
    logic [31:0] a, b;
    int          elat, lat;
    a = $urandom();
    b = $urandom();
    model(MD_MULT, a, b, elat);
    start_op(MD_MULT, a, b);
    repeat (4) tick();
    start_op(MD_DIVU, $urandom(), 32'd3);
    lat = 6;
    wait_done(lat);
    checks++;
    if (lat !== 34 || {bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin
      failures++;
      $display("FAIL ignored_start act=lat%0d %h_%h exp=lat34 %h_%h", lat, bus.Hi, bus.Lo, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int lat, elat;
    start_op(MD_DIV, 32'hFFFF1234, 32'd77);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    checks++;
    if ({bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo} !== 67'd0) begin
      failures++;
      $display("FAIL reset_mid act=busy%b done%b dz%b %h_%h exp=all0",
               bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo);
    end
    model(MD_DIV, 32'd1000, 32'hFFFFFFF9, elat);
    start_op(MD_DIV, 32'd1000, 32'hFFFFFFF9);
    lat = 1;
    wait_done(lat);
    checks++;
    if (lat !== elat || {bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin
      failures++;
      $display("FAIL reset_restart act=lat%0d %h_%h exp=lat%0d %h_%h",
               lat, bus.Hi, bus.Lo, elat, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    logic [31:0] h1, l1;
    int          elat, lat;
    a1 = $urandom();
    b1 = $urandom();
    a2 = $urandom();
    b2 = $urandom_range(1, 1000);
    model(MD_MULTU, a1, b1, elat);
    h1 = exp_hi;
    l1 = exp_lo;
    start_op(MD_MULTU, a1, b1);
    lat = 1;
    wait_done(lat);
    checks++;
    if (lat !== 34 || {bus.Hi, bus.Lo} !== {h1, l1}) begin
      failures++;
      $display("FAIL b2b_first act=lat%0d %h_%h exp=lat34 %h_%h", lat, bus.Hi, bus.Lo, h1, l1);
    end
    model(MD_DIV, a2, b2, elat);
    start_op(MD_DIV, a2, b2);
    checks++;
    if ({bus.Done, bus.Busy} !== 2'b01 || {bus.Hi, bus.Lo} !== {h1, l1}) begin
      failures++;
      $display("FAIL b2b_accept act=done%b busy%b %h_%h exp=done0 busy1 %h_%h",
               bus.Done, bus.Busy, bus.Hi, bus.Lo, h1, l1);
    end
    lat = 1;
    wait_done(lat);
    checks++;
    if (lat !== 34 || {bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin
      failures++;
      $display("FAIL b2b_second act=lat%0d %h_%h exp=lat34 %h_%h", lat, bus.Hi, bus.Lo, exp_hi, exp_lo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
